// File: rtl/instr_step_fetch.sv
// Single-step instruction fetch: debounced step button walks a 16x16 program memory
// and presents the latched instruction fields plus a scan toggle to the 7-seg display.
//
// state | meaning
// IDLE  | waiting for a debounced step press
// FETCH | registered read of mem[pc] done; write-through from the load port allowed
// LATCH | fields/pc/instr_valid update on the closing edge
module instr_step_fetch #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_step,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic [3:0]  Opcode,
  output logic [3:0]  Rd1,
  output logic [3:0]  Rd2,
  output logic [3:0]  Wr,
  output logic [3:0]  pc,
  output logic        instr_valid,
  output logic        scan
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH} state_t;

  state_t          state;
  logic            sync1, sync2;
  logic            db_level, db_prev;
  logic [DB_W-1:0] db_cnt;
  logic [SC_W-1:0] scan_cnt;
  logic [15:0]     mem [16];
  logic [15:0]     fetch_word;
  logic            step;

  assign step = db_level & ~db_prev;

  // Program memory is deliberately left out of reset so a reset keeps the loaded program.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1   <= btn_step;
      sync2   <= sync1;
      db_prev <= db_level;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan     <= 1'b0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt <= '0;
      scan     <= ~scan;
    end else begin
      scan_cnt <= scan_cnt + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_word  <= '0;
      Opcode      <= '0;
      Rd1         <= '0;
      Rd2         <= '0;
      Wr          <= '0;
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (step) begin
            fetch_word <= mem[pc];
            state      <= FETCH;
          end
        end
        FETCH: begin
          // A load to the address being fetched wins over the word read last cycle.
          if (ld_en && (ld_addr == pc)) fetch_word <= ld_data;
          state <= LATCH;
        end
        LATCH: begin
          Opcode      <= fetch_word[15:12];
          Rd1         <= fetch_word[11:8];
          Rd2         <= fetch_word[7:4];
          Wr          <= fetch_word[3:0];
          pc          <= pc + 4'd1;
          instr_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_step_fetch.sv
// Bench for instr_step_fetch with DEBOUNCE_CYCLES=8, SCAN_DIV=4: table-driven loads/presses,
// scoreboard of expected fetches, and hand sequences for debounce, wrap, write-through, drop, reset.
module tb_instr_step_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_step = 1'b0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [3:0]  Opcode, Rd1, Rd2, Wr, pc;
  logic        instr_valid, scan;

  instr_step_fetch #(.DEBOUNCE_CYCLES(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_step(btn_step),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .Opcode(Opcode), .Rd1(Rd1), .Rd2(Rd2), .Wr(Wr),
    .pc(pc), .instr_valid(instr_valid), .scan(scan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op, rd1, rd2, wr, pc;
  } exp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [3:0]  op, rd1, rd2, wr;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[4];
  logic [15:0] mem_m[16];
  logic [3:0]  pc_m;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    exp_t e;
    e.op = w[15:12]; e.rd1 = w[11:8]; e.rd2 = w[7:4]; e.wr = w[3:0];
    e.pc = pc_m + 4'd1;
    sb.push_back(e);
  endtask

  // Wait (bounded) for pc to leave its modelled value, then pop and compare.
  task automatic wait_and_compare(input string tag);
    exp_t e;
    bit   seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (pc !== pc_m) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: pc stuck at %h expected change", tag, pc);
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_sb_empty: got output expected queued entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_op"},  {12'h0, Opcode}, {12'h0, e.op});
      check({tag, "_rd1"}, {12'h0, Rd1},    {12'h0, e.rd1});
      check({tag, "_rd2"}, {12'h0, Rd2},    {12'h0, e.rd2});
      check({tag, "_wr"},  {12'h0, Wr},     {12'h0, e.wr});
      check({tag, "_pc"},  {12'h0, pc},     {12'h0, e.pc});
      check({tag, "_valid"}, {15'h0, instr_valid}, 16'h1);
      pc_m = e.pc;
    end
  endtask

  task automatic release_btn();
    btn_step = 1'b0;
    repeat (14) tick();
  endtask

  task automatic press(input string tag, input logic [15:0] w);
    push_word(w);
    btn_step = 1'b1;
    wait_and_compare(tag);
    release_btn();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fields"}, {Opcode, Rd1, Rd2, Wr}, 16'h0);
    check({tag, "_pc"}, {12'h0, pc}, 16'h0);
    check({tag, "_valid"}, {15'h0, instr_valid}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1);
  end

  initial begin
    int change_c;
    int changes;
    logic [3:0] pc_last;
    logic [3:0] a;

    vecs[0] = '{4'h0, 16'h1234, 4'h1, 4'h2, 4'h3, 4'h4};
    vecs[1] = '{4'h1, 16'hABCD, 4'hA, 4'hB, 4'hC, 4'hD};
    vecs[2] = '{4'h2, 16'h5E60, 4'h5, 4'hE, 4'h6, 4'h0};
    vecs[3] = '{4'h3, 16'h0F1C, 4'h0, 4'hF, 4'h1, 4'hC};
    pc_m = 4'h0;

    // Reset and scan
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    check_zero("reset");
    check("reset_scan", {15'h0, scan}, 16'h0);
    for (int n = 1; n <= 24; n++) begin
      tick();
      check("scan", {15'h0, scan}, 16'((n / 4) % 2));
      check("idle_stable", {Opcode, Rd1, Rd2, Wr}, 16'h0);
      check("idle_valid", {15'h0, instr_valid}, 16'h0);
    end

    // Load program memory
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      mem_m[i] = (i < 4) ? vecs[i].data : {a, a + 4'h3, ~a, a ^ 4'h5};
      ld_en = 1'b1; ld_addr = a; ld_data = mem_m[i];
      tick();
    end
    ld_en = 1'b0;
    repeat (2) tick();

    // Table-driven first two presses, expected fields straight from the table
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.op = vecs[i].op; e.rd1 = vecs[i].rd1; e.rd2 = vecs[i].rd2; e.wr = vecs[i].wr;
      e.pc = vecs[i].addr + 4'd1;
      sb.push_back(e);
      btn_step = 1'b1;
      wait_and_compare("table");
      release_btn();
    end

    // Bouncing button: 14 phases of 3 cycles, then hold high from c=42
    push_word(mem_m[2]);
    change_c = -1;
    changes = 0;
    pc_last = pc;
    for (int c = 0; c < 90; c++) begin
      btn_step = (c < 42) ? (((c / 3) % 2) == 0) : 1'b1;
      tick();
      if (pc !== pc_last) begin
        changes++;
        if (change_c < 0) change_c = c;
        pc_last = pc;
      end
    end
    check("debounce_changes", 16'(changes), 16'd1);
    check("debounce_latency", 16'(change_c), 16'd54);
    begin
      exp_t e;
      e = sb.pop_front();
      check("debounce_fields", {Opcode, Rd1, Rd2, Wr}, {e.op, e.rd1, e.rd2, e.wr});
      check("debounce_pc", {12'h0, pc}, {12'h0, e.pc});
      pc_m = e.pc;
    end
    release_btn();
    press("press3", mem_m[3]);

    // PC wrap from a fresh reset; memory must survive the reset
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    pc_m = 4'h0;
    check_zero("reset2");
    for (int i = 0; i < 16; i++) press("wrap", mem_m[i]);
    check("wrap_pc0", {12'h0, pc}, 16'h0);
    press("refetch0", mem_m[0]);
    for (int i = 1; i < 5; i++) press("to_pc5", mem_m[i]);
    check("at_pc5", {12'h0, pc}, 16'h5);

    // Write-through during FETCH (pc=5)
    push_word(16'h9F07);
    btn_step = 1'b1;
    repeat (11) tick();
    ld_en = 1'b1; ld_addr = 4'h5; ld_data = 16'h9F07;
    tick();
    ld_en = 1'b0;
    mem_m[5] = 16'h9F07;
    wait_and_compare("wthru");
    release_btn();

    // Step forced high across FETCH and LATCH must be dropped
    push_word(mem_m[6]);
    btn_step = 1'b1;
    repeat (11) tick();
    force dut.step = 1'b1;
    tick();
    tick();
    release dut.step;
    wait_and_compare("drop");
    repeat (10) tick();
    check("drop_pc_hold", {12'h0, pc}, 16'h7);
    release_btn();

    // Reset during LATCH aborts the fetch
    btn_step = 1'b1;
    repeat (12) tick();
    rst_n = 1'b0;
    btn_step = 1'b0;
    tick();
    check_zero("rst_latch");
    rst_n = 1'b1;
    pc_m = 4'h0;
    repeat (14) tick();
    press("post_rst", mem_m[0]);

    check("sb_drained", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
